alu_exec_stage: RTL

//  Registered execute stage; sits directly downstream of alu_control.
//  - Takes alu_ctr plus two operands and a destination tag from the ID/EX boundary.
//  - Computes the ALU result and registers it with valid/ready flow control.
//  - Feeds the EX/MEM stage.
//  - A 2-entry skid buffer keeps in_ready a registered signal, so backpressure never forms a

---
 rtl/alu_exec_stage_pkg.sv | 28 ++
 rtl/alu_exec_stage_core.sv | 55 +++++
 rtl/alu_exec_stage.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/alu_exec_stage_pkg.sv
`default_nettype none
// ============================================================================
// Package     : alu_exec_stage_pkg
// Description : Shared ALU opcode encodings and default widths for the
//               execute stage and its combinational ALU core.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_exec_stage_pkg;

  // Default operand/result width and destination-tag width
  localparam int unsigned WIDTH_DEFAULT = 32;
  localparam int unsigned TAG_W_DEFAULT = 5;

  // alu_ctr encodings produced by alu_control
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b100;
  localparam logic [2:0] ALU_ADD = 3'b101;
  localparam logic [2:0] ALU_SUB = 3'b110;

  // True for the codes alu_control never issues (010, 011, 111)
  function automatic logic is_reserved(input logic [2:0] ctr);
    return !(ctr == ALU_AND || ctr == ALU_OR || ctr == ALU_SLT ||
             ctr == ALU_ADD || ctr == ALU_SUB);
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu_exec_stage_core.sv
`default_nettype none
// ============================================================================
// Module      : alu_core
// Description : Purely combinational ALU: AND/OR/ADD/SUB/SLT with zero,
//               signed-overflow and reserved-opcode flags.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_core
  import alu_exec_stage_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic [2:0]       alu_ctr,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             ovf,
  output logic             illegal
);

  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;
  logic             a_lt_b;

  assign sum    = op_a + op_b;
  assign diff   = op_a - op_b;
  // Direct signed compare so SLT stays correct when A-B overflows
  assign a_lt_b = $signed(op_a) < $signed(op_b);

  // Select the operation result and its flags
  always_comb begin
    result  = '0;
    ovf     = 1'b0;
    illegal = 1'b0;
    case (alu_ctr)
      ALU_AND: result = op_a & op_b;
      ALU_OR:  result = op_a | op_b;
      ALU_ADD: begin
        result = sum;
        ovf    = (op_a[WIDTH-1] == op_b[WIDTH-1]) && (sum[WIDTH-1] != op_a[WIDTH-1]);
      end
      ALU_SUB: begin
        result = diff;
        ovf    = (op_a[WIDTH-1] != op_b[WIDTH-1]) && (diff[WIDTH-1] != op_a[WIDTH-1]);
      end
      ALU_SLT: result = {{(WIDTH-1){1'b0}}, a_lt_b};
      default: illegal = 1'b1;
    endcase
  end

  assign zero = (result == '0);

endmodule
`default_nettype wire

// File: rtl/alu_exec_stage.sv
`default_nettype none
// ============================================================================
// Module      : alu_exec_stage
// Description : Registered execute stage. One ALU core ahead of a 2-entry
//               (main + skid) result buffer with valid/ready on both sides;
//               in_ready comes straight from a flop.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_exec_stage
  import alu_exec_stage_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT,
  parameter int TAG_W = TAG_W_DEFAULT
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       alu_ctr,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_zero,
  output logic             out_ovf,
  output logic             out_illegal,
  output logic [TAG_W-1:0] out_tag
);

  // Entry layout: {result, zero, ovf, illegal, tag}
  localparam int ENTRY_W = WIDTH + 3 + TAG_W;

  logic [WIDTH-1:0]   core_result;
  logic               core_zero;
  logic               core_ovf;
  logic               core_illegal;

  logic [ENTRY_W-1:0] new_entry;
  logic [ENTRY_W-1:0] main_entry;
  logic [ENTRY_W-1:0] skid_entry;
  logic               main_v;
  logic               skid_v;
  logic               ready_q;

  logic               accept;
  logic               pop;
  logic               main_v_nx;
  logic               skid_v_nx;
  logic               load_main_new;
  logic               load_main_skid;
  logic               load_skid;

  alu_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .alu_ctr (alu_ctr),
    .op_a    (op_a),
    .op_b    (op_b),
    .result  (core_result),
    .zero    (core_zero),
    .ovf     (core_ovf),
    .illegal (core_illegal)
  );

  assign new_entry = {core_result, core_zero, core_ovf, core_illegal, in_tag};

  assign accept = in_valid & ready_q;
  assign pop    = main_v & out_ready;

  // Buffer occupancy update and entry-move decisions, flush first
  always_comb begin
    main_v_nx      = main_v;
    skid_v_nx      = skid_v;
    load_main_new  = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    if (flush) begin
      main_v_nx = 1'b0;
      skid_v_nx = 1'b0;
    end else if (pop) begin
      if (skid_v) begin
        load_main_skid = 1'b1;
        skid_v_nx      = 1'b0;
        // Unreachable while in_ready tracks !skid_v; kept so order is preserved regardless
        if (accept) begin
          load_skid = 1'b1;
          skid_v_nx = 1'b1;
        end
      end else if (accept) begin
        load_main_new = 1'b1;
      end else begin
        main_v_nx = 1'b0;
      end
    end else if (accept) begin
      if (!main_v) begin
        load_main_new = 1'b1;
        main_v_nx     = 1'b1;
      end else begin
        load_skid = 1'b1;
        skid_v_nx = 1'b1;
      end
    end
  end

  // Valid flags and the registered in_ready (true whenever the skid slot is free)
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      main_v  <= 1'b0;
      skid_v  <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      main_v  <= main_v_nx;
      skid_v  <= skid_v_nx;
      ready_q <= !skid_v_nx;
    end
  end

  // Entry payloads: computed results, never operands
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      main_entry <= '0;
      skid_entry <= '0;
    end else begin
      if (load_main_new) begin
        main_entry <= new_entry;
      end else if (load_main_skid) begin
        main_entry <= skid_entry;
      end
      if (load_skid) begin
        skid_entry <= new_entry;
      end
    end
  end

  assign in_ready  = ready_q;
  assign out_valid = main_v;
  assign {out_result, out_zero, out_ovf, out_illegal, out_tag} = main_entry;

endmodule
`default_nettype wire
